// File: rtl/lpif_pkg.sv
// Shared LPIF state encodings, internal controller states and the fixed protocol code.
// Optional L1 support is compiled in with LPIF_L1_EN.
package lpif_pkg;

  typedef enum logic [3:0] {
    LPIF_RESET     = 4'b0000,
    LPIF_ACTIVE    = 4'b0001,
    LPIF_L1        = 4'b0100,
    LPIF_LINKRESET = 4'b1001,
    LPIF_RETRAIN   = 4'b1011,
    LPIF_DISABLED  = 4'b1100
  } lpif_state_e;

  // STALL is internal only; it reports as ACTIVE on state_sts.
  typedef enum logic [2:0] {
    ST_RESET,
    ST_ACTIVE,
    ST_RETRAIN,
    ST_STALL,
    ST_LINKRESET,
    ST_DISABLED
`ifdef LPIF_L1_EN
    , ST_L1
`endif
  } fsm_e;

  localparam logic [2:0] PROTOCOL_PCIE = 3'b000;

  function automatic logic [3:0] sts_of(input fsm_e s);
    case (s)
      ST_ACTIVE, ST_STALL: sts_of = LPIF_ACTIVE;
      ST_RETRAIN:          sts_of = LPIF_RETRAIN;
      ST_LINKRESET:        sts_of = LPIF_LINKRESET;
      ST_DISABLED:         sts_of = LPIF_DISABLED;
`ifdef LPIF_L1_EN
      ST_L1:               sts_of = LPIF_L1;
`endif
      default:             sts_of = LPIF_RESET;
    endcase
  endfunction

  function automatic logic up_of(input fsm_e s);
    case (s)
      ST_ACTIVE, ST_RETRAIN, ST_STALL: up_of = 1'b1;
`ifdef LPIF_L1_EN
      ST_L1:                           up_of = 1'b1;
`endif
      default:                         up_of = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lpif_stall_timer.sv
// Counts cycles spent in STALL; expired flags the TIMEOUT-th cycle so the exit lands on that edge.
// Counter clears on stall entry and saturates at TIMEOUT.
module lpif_stall_timer #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             cnt <= '0;
    else if (clear)                        cnt <= '0;
    else if (enable && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt >= W'(TIMEOUT - 1));

endmodule

// File: rtl/lpif_state_ctrl.sv
// LPIF PHY-side state controller: RESET/ACTIVE/RETRAIN/LINKRESET/DISABLED plus a stall handshake.
// L1 entry is built only when LPIF_L1_EN is defined; all outputs are registered.
module lpif_state_ctrl
  import lpif_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state_req,
  input  logic       stall_ack,
  input  logic       ltssm_l0,
  input  logic       ltssm_recovery,
  input  logic [2:0] lane_width,
  output logic [3:0] state_sts,
  output logic       link_up,
  output logic       stall_req,
  output logic       protocol_valid,
  output logic [2:0] protocol,
  output logic [2:0] link_cfg,
  output logic       phyinrecenter,
  output logic       phyinl1
);

  localparam int CW = ($clog2(STALL_TIMEOUT + 1) > 8) ? $clog2(STALL_TIMEOUT + 1) : 8;

  fsm_e state, nxt, tgt, req_tgt;
  logic link_down, req_stall, stall_exp;

  assign link_down = !ltssm_l0 && !ltssm_recovery;

  always_comb begin
    req_stall = 1'b1;
    req_tgt   = ST_LINKRESET;
    case (state_req)
      LPIF_LINKRESET: req_tgt = ST_LINKRESET;
      LPIF_DISABLED:  req_tgt = ST_DISABLED;
`ifdef LPIF_L1_EN
      LPIF_L1:        req_tgt = ST_L1;
`endif
      default:        req_stall = 1'b0;
    endcase
  end

  // Priority: link down, then recovery, then ack/timeout, then state_req.
  always_comb begin
    nxt = state;
    case (state)
      ST_RESET:
        if (state_req == LPIF_ACTIVE && ltssm_l0) nxt = ST_ACTIVE;
      ST_ACTIVE:
        if (link_down)           nxt = ST_RESET;
        else if (ltssm_recovery) nxt = ST_RETRAIN;
        else if (req_stall)      nxt = ST_STALL;
      ST_RETRAIN:
        if (link_down)           nxt = ST_RESET;
        else if (ltssm_l0 && !ltssm_recovery) nxt = ST_ACTIVE;
      ST_STALL:
        if (link_down)                   nxt = ST_RESET;
        else if (ltssm_recovery)         nxt = ST_RETRAIN;
        else if (stall_ack || stall_exp) nxt = tgt;
      ST_LINKRESET, ST_DISABLED:
        if (state_req == LPIF_ACTIVE) nxt = ST_RESET;
`ifdef LPIF_L1_EN
      ST_L1:
        if (link_down)                     nxt = ST_RESET;
        else if (state_req == LPIF_ACTIVE) nxt = ST_RETRAIN;
`endif
      default: nxt = ST_RESET;
    endcase
  end

  lpif_stall_timer #(.TIMEOUT(STALL_TIMEOUT), .W(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_ACTIVE && nxt == ST_STALL),
    .enable  (state == ST_STALL),
    .expired (stall_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RESET;
      tgt            <= ST_LINKRESET;
      state_sts      <= LPIF_RESET;
      link_up        <= 1'b0;
      stall_req      <= 1'b0;
      protocol_valid <= 1'b0;
      protocol       <= '0;
      link_cfg       <= '0;
      phyinrecenter  <= 1'b0;
      phyinl1        <= 1'b0;
    end else begin
      state          <= nxt;
      if (state == ST_ACTIVE && nxt == ST_STALL) tgt <= req_tgt;
      state_sts      <= sts_of(nxt);
      link_up        <= up_of(nxt);
      stall_req      <= (nxt == ST_STALL);
      protocol_valid <= (state == ST_RESET && nxt == ST_ACTIVE);
      if (state == ST_RESET && nxt == ST_ACTIVE) link_cfg <= lane_width;
      protocol       <= PROTOCOL_PCIE;
      phyinrecenter  <= (nxt == ST_RETRAIN);
`ifdef LPIF_L1_EN
      phyinl1        <= (nxt == ST_L1);
`else
      phyinl1        <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_lpif_state_ctrl.sv
// Randomized bench for lpif_state_ctrl against a behavioural LPIF model, plus directed scenarios.
module tb_lpif_state_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state_req = 4'h0;
  logic       stall_ack = 1'b0;
  logic       ltssm_l0 = 1'b0;
  logic       ltssm_recovery = 1'b0;
  logic [2:0] lane_width = 3'h0;
  logic [3:0] state_sts;
  logic       link_up, stall_req, protocol_valid, phyinrecenter, phyinl1;
  logic [2:0] protocol, link_cfg;

  int checks = 0;
  int errors = 0;

  lpif_state_ctrl #(.STALL_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .state_req(state_req), .stall_ack(stall_ack),
    .ltssm_l0(ltssm_l0), .ltssm_recovery(ltssm_recovery), .lane_width(lane_width),
    .state_sts(state_sts), .link_up(link_up), .stall_req(stall_req),
    .protocol_valid(protocol_valid), .protocol(protocol), .link_cfg(link_cfg),
    .phyinrecenter(phyinrecenter), .phyinl1(phyinl1)
  );

  always #5 clk = ~clk;

  // Model: visible LPIF code, a stalling flag, elapsed stall cycles and the requested target.
  logic [3:0] m_sts, m_tgt;
  logic       m_stall, m_pv;
  logic [2:0] m_cfg;
  int         m_cnt;

  function automatic bit is_stall_req(input logic [3:0] sr);
`ifdef LPIF_L1_EN
    return sr == 4'b1001 || sr == 4'b1100 || sr == 4'b0100;
`else
    return sr == 4'b1001 || sr == 4'b1100;
`endif
  endfunction

  task automatic model_reset();
    m_sts = 4'b0000; m_tgt = 4'b0000; m_stall = 0; m_pv = 0; m_cfg = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] sr, input logic ack, input logic l0,
                            input logic rec, input logic [2:0] lw);
    bit down;
    down = !l0 && !rec;
    m_pv = 0;
    if (m_stall) begin
      m_cnt++;
      if (down) begin m_stall = 0; m_sts = 4'b0000; end
      else if (rec) begin m_stall = 0; m_sts = 4'b1011; end
      else if (ack || m_cnt >= TO) begin m_stall = 0; m_sts = m_tgt; end
    end else begin
      case (m_sts)
        4'b0000: if (sr == 4'b0001 && l0) begin m_sts = 4'b0001; m_pv = 1; m_cfg = lw; end
        4'b0001: if (down) m_sts = 4'b0000;
                 else if (rec) m_sts = 4'b1011;
                 else if (is_stall_req(sr)) begin m_stall = 1; m_cnt = 0; m_tgt = sr; end
        4'b1011: if (down) m_sts = 4'b0000;
                 else if (l0 && !rec) m_sts = 4'b0001;
        4'b1001, 4'b1100: if (sr == 4'b0001) m_sts = 4'b0000;
        4'b0100: if (down) m_sts = 4'b0000;
                 else if (sr == 4'b0001) m_sts = 4'b1011;
        default: m_sts = 4'b0000;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic up;
    up = m_stall || m_sts == 4'b0001 || m_sts == 4'b1011 || m_sts == 4'b0100;
    check("state_sts", 32'(state_sts), 32'(m_stall ? 4'b0001 : m_sts));
    check("link_up", 32'(link_up), 32'(up));
    check("stall_req", 32'(stall_req), 32'(m_stall));
    check("protocol_valid", 32'(protocol_valid), 32'(m_pv));
    check("protocol", 32'(protocol), 32'h0);
    check("link_cfg", 32'(link_cfg), 32'(m_cfg));
    check("phyinrecenter", 32'(phyinrecenter), 32'(!m_stall && m_sts == 4'b1011));
    check("phyinl1", 32'(phyinl1), 32'(!m_stall && m_sts == 4'b0100));
  endtask

  // Drive one cycle of inputs just after a falling edge, advance the model, compare at the next falling edge.
  task automatic cycle(input logic [3:0] sr, input logic ack, input logic l0,
                       input logic rec, input logic [2:0] lw);
    state_req = sr; stall_ack = ack; ltssm_l0 = l0; ltssm_recovery = rec; lane_width = lw;
    model_step(sr, ack, l0, rec, lw);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] sr;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_sts", 32'(state_sts), 32'h0);
    check("rst_link_up", 32'(link_up), 32'h0);
    reset = 1'b0;

    // Bring-up
    cycle(4'h0, 0, 1, 0, 3'd5);
    check("idle_sts", 32'(state_sts), 32'h0);
    cycle(4'h1, 0, 1, 0, 3'd5);
    check("up_sts", 32'(state_sts), 32'h1);
    check("up_link", 32'(link_up), 32'h1);
    check("up_pv", 32'(protocol_valid), 32'h1);
    check("up_cfg", 32'(link_cfg), 32'h5);
    cycle(4'h1, 0, 1, 0, 3'd2);
    check("pv_once", 32'(protocol_valid), 32'h0);
    check("cfg_held", 32'(link_cfg), 32'h5);

    // Retrain
    repeat (5) cycle(4'h1, 0, 0, 1, 3'd2);
    check("retrain_sts", 32'(state_sts), 32'hB);
    check("retrain_flag", 32'(phyinrecenter), 32'h1);
    check("retrain_up", 32'(link_up), 32'h1);
    cycle(4'h1, 0, 1, 0, 3'd2);
    check("retrain_back", 32'(state_sts), 32'h1);
    check("retrain_nopv", 32'(protocol_valid), 32'h0);

    // DISABLED with ack on the 10th stall cycle
    cycle(4'hC, 0, 1, 0, 3'd2);
    n = stall_req ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(4'hC, (i == 10), 1, 0, 3'd2);
      if (stall_req) n++;
    end
    check("dis_stall_cycles", 32'(n), 32'd10);
    check("dis_sts", 32'(state_sts), 32'hC);
    check("dis_link_up", 32'(link_up), 32'h0);
    cycle(4'h1, 0, 1, 0, 3'd2);
    check("dis_to_reset", 32'(state_sts), 32'h0);
    cycle(4'h1, 0, 1, 0, 3'd2);

    // LINKRESET by timeout
    cycle(4'h9, 0, 1, 0, 3'd2);
    n = stall_req ? 1 : 0;
    for (int i = 0; i < 40 && stall_req; i++) begin
      cycle(4'h9, 0, 1, 0, 3'd2);
      if (stall_req) n++;
    end
    check("to_stall_cycles", 32'(n), 32'd16);
    check("to_sts", 32'(state_sts), 32'h9);
    check("to_stall_req", 32'(stall_req), 32'h0);
    cycle(4'h1, 0, 1, 0, 3'd2);
    cycle(4'h1, 0, 1, 0, 3'd2);

    // Link down beats ack
    cycle(4'hC, 0, 1, 0, 3'd2);
    cycle(4'hC, 1, 0, 0, 3'd2);
    check("down_sts", 32'(state_sts), 32'h0);
    check("down_up", 32'(link_up), 32'h0);
    check("down_stall", 32'(stall_req), 32'h0);

    // Reset mid-stall
    cycle(4'h1, 0, 1, 0, 3'd6);
    cycle(4'h9, 0, 1, 0, 3'd6);
    cycle(4'h9, 0, 1, 0, 3'd6);
    #2 reset = 1'b1;
    #1;
    check("arst_sts", 32'(state_sts), 32'h0);
    check("arst_stall", 32'(stall_req), 32'h0);
    check("arst_up", 32'(link_up), 32'h0);
    check("arst_cfg", 32'(link_cfg), 32'h0);
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // L1 request
    cycle(4'h1, 0, 1, 0, 3'd1);
`ifdef LPIF_L1_EN
    cycle(4'h4, 0, 1, 0, 3'd1);
    cycle(4'h4, 1, 1, 0, 3'd1);
    check("l1_flag", 32'(phyinl1), 32'h1);
    check("l1_sts", 32'(state_sts), 32'h4);
    cycle(4'h1, 0, 1, 0, 3'd1);
    check("l1_exit_retrain", 32'(state_sts), 32'hB);
    cycle(4'h1, 0, 1, 0, 3'd1);
    check("l1_exit_active", 32'(state_sts), 32'h1);
`else
    repeat (3) cycle(4'h4, 1, 1, 0, 3'd1);
    check("l1_ignored_sts", 32'(state_sts), 32'h1);
    check("l1_ignored_stall", 32'(stall_req), 32'h0);
    check("l1_ignored_flag", 32'(phyinl1), 32'h0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: sr = 4'b0001;
          4:          sr = 4'b1001;
          5:          sr = 4'b1100;
          6:          sr = 4'b0100;
          7:          sr = 4'b0000;
          8:          sr = 4'b1011;
          default:    sr = 4'($urandom_range(0, 15));
        endcase
        cycle(sr,
              (c < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 15) != 0),
              ($urandom_range(0, 11) == 0),
              3'($urandom_range(0, 7)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpif_state_ctrl.md
LPIF_STATE_CTRL -- requirements
Module: lpif_state_ctrl

Interface
REQ-001 Parameter STALL_TIMEOUT, default 255, max cycles stall_req waits for stall_ack.
REQ-002 Clk  input  1  sole clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 state_req  input  4  link-layer state request, LPIF encoding.
REQ-005 stall_ack  input  1  link layer has drained traffic.
REQ-006 ltssm_l0  input  1  PHY LTSSM in L0.
REQ-007 ltssm_recovery  input  1  PHY LTSSM in Recovery.
REQ-008 lane_width  input  3  negotiated width code from LTSSM.
REQ-009 state_sts  output  4  current LPIF state.
REQ-010 link_up  output  1  link usable for traffic.
REQ-011 stall_req  output  1  PHY requests traffic stall.
REQ-012 protocol_valid  output  1  one-cycle pulse; protocol is valid.
REQ-013 protocol  output  3  negotiated protocol, fixed 3'b000 (PCIe).
REQ-014 link_cfg  output  3  latched lane_width.
REQ-015 phyinrecenter  output  1  high while in RETRAIN.
REQ-016 phyinl1  output  1  high while in L1.

Function
REQ-017 Encodings SHALL be RESET 4'b0000, ACTIVE 4'b0001, L1 4'b0100, LINKRESET 4'b1001, RETRAIN 4'b1011, DISABLED 4'b1100; other state_req codes ignored.
REQ-018 RESET->ACTIVE SHALL occur on the cycle after state_req==ACTIVE and ltssm_l0==1 both sampled high.
REQ-019 On ACTIVE entry: link_up=1, link_cfg<=lane_width, protocol_valid high exactly one cycle.
REQ-020 ACTIVE->RETRAIN SHALL occur the cycle after ltssm_recovery==1; RETRAIN->ACTIVE the cycle after ltssm_l0==1 && ltssm_recovery==0; link_up stays 1 in RETRAIN; no protocol_valid pulse on return.
REQ-021 ACTIVE with state_req in {LINKRESET, DISABLED, L1} SHALL enter internal STALL substate: stall_req=1, state_sts remains ACTIVE, target latched.
REQ-022 STALL SHALL exit to latched target on the cycle after stall_ack==1 or after STALL_TIMEOUT cycles without ack; stall_req deasserts in that same cycle.
REQ-023 Stall counter SHALL be 8-bit-or-wider, clear on STALL entry, saturate at STALL_TIMEOUT, never wrap.
REQ-024 LINKRESET and DISABLED SHALL drive link_up=0 and return to RESET the cycle after state_req==ACTIVE.
REQ-025 In ACTIVE, RETRAIN or STALL, ltssm_l0==0 && ltssm_recovery==0 SHALL force RESET next cycle, link_up=0, stall_req=0.
REQ-026 Priority per cycle SHALL be: link down > ltssm_recovery > stall_ack/timeout > state_req.
REQ-027 ltssm_recovery during STALL SHALL abandon the stall (stall_req=0) and enter RETRAIN.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 reset SHALL immediately set state_sts=RESET, link_up=0, stall_req=0, protocol_valid=0, protocol=0, link_cfg=0, phyinrecenter=0, phyinl1=0, stall counter=0, including mid-STALL.

Configuration
REQ-030 Macro LPIF_L1_EN defined: L1 request stalls then enters L1, phyinl1=1, link_up=1; state_req==ACTIVE in L1 -> RETRAIN next cycle; link down in L1 -> RESET.
REQ-031 Macro LPIF_L1_EN undefined: state_req==L1 ignored in ACTIVE, phyinl1 tied 0, no L1 state exists.

Structure
REQ-032 State encodings (enum typedef) and protocol constant SHALL live in shared package lpif_pkg.
REQ-033 Stall timeout counter SHALL be sub-module lpif_stall_timer (clear, enable, expired).

Verification
REQ-034 reset release, state_req=0001, ltssm_l0=1 -> state_sts=0001 next cycle, link_up=1, one protocol_valid pulse, link_cfg=lane_width.
REQ-035 ACTIVE, ltssm_recovery=1 for 5 cycles then ltssm_l0=1 -> state_sts 1011 with phyinrecenter=1, then 0001.
REQ-036 ACTIVE, state_req=1100, stall_ack after 10 cycles -> stall_req high 10 cycles, then state_sts=1100, link_up=0.
REQ-037 ACTIVE, state_req=1001, no stall_ack, STALL_TIMEOUT=16 -> LINKRESET after 16 cycles, stall_req=0.
REQ-038 STALL with stall_ack and ltssm_l0=0 same cycle -> RESET, link_up=0; reset asserted mid-STALL -> all outputs 0 immediately.
REQ-039 LPIF_L1_EN: state_req=0100, stall_ack -> phyinl1=1; state_req=0001 -> RETRAIN then ACTIVE; without macro, state_sts stays 0001.
